// File: rtl/udp_seq_eval_if.sv
// udp_seq_eval_if: bundles the configuration port, the input-vector handshake
// and the result handshake of the sequential UDP evaluator.
//   master : drives config, input vectors and out_ready (bench / upstream)
//   slave  : the evaluator; drives locked, in_ready and the result signals
`timescale 1ns/1ps
interface udp_seq_eval_if #(
    parameter int NIN = 2
);
    logic             cfg_we;
    logic [NIN:0]     cfg_addr;
    logic [1:0]       cfg_data;
    logic             cfg_lock;
    logic             locked;
    logic             in_valid;
    logic             in_ready;
    logic [NIN-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out;
    logic             out_changed;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_lock,
        output in_valid, in_data, out_ready,
        input  locked, in_ready, out_valid, out, out_changed
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_lock,
        input  in_valid, in_data, out_ready,
        output locked, in_ready, out_valid, out, out_changed
    );
endinterface

// File: rtl/udp_seq_eval.sv
// udp_seq_eval: level-sensitive sequential UDP with one state bit.
// A truth table indexed by {state, inputs} is written in LOAD, frozen by
// cfg_lock, and then one input vector is evaluated per accepted handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active high (back to LOAD, table = hold, out = INIT)
//   bus  - udp_seq_eval_if.slave: cfg_we/cfg_addr/cfg_data/cfg_lock, locked,
//          in_valid/in_ready/in_data, out_valid/out_ready/out/out_changed
`timescale 1ns/1ps
module udp_seq_eval #(
    parameter int   NIN  = 2,
    parameter logic INIT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    udp_seq_eval_if.slave  bus
);
    localparam int DEPTH = 2 ** (NIN + 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       state_r;
    state_t       state_nxt_s;
    logic [1:0]   table_r [DEPTH];
    logic         out_r;
    logic         out_valid_r;
    logic         out_changed_r;
    logic         in_ready_s;
    logic         accept_s;
    logic [NIN:0] idx_s;
    logic [1:0]   code_s;
    logic         next_s;

    // Output slot is free when empty or being drained this cycle; never ready in LOAD.
    assign in_ready_s = (state_r == ST_RUN) && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign idx_s      = {out_r, bus.in_data};
    assign code_s     = table_r[idx_s];

    assign bus.in_ready    = in_ready_s;
    assign bus.locked      = (state_r == ST_RUN);
    assign bus.out         = out_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_changed = out_changed_r;

    // Mode state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Mode transitions: LOAD exits on cfg_lock, RUN is left only by reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (bus.cfg_lock) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_LOAD;
        endcase
    end

    // Decode the table entry into the next state bit (10 and 11 both hold).
    always_comb begin
        next_s = out_r;
        case (code_s)
            2'b00:   next_s = 1'b0;
            2'b01:   next_s = 1'b1;
            default: next_s = out_r;
        endcase
    end

    // Truth table: cleared to hold on reset, writable only while in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= 2'b10;
            end
        end else if ((state_r == ST_LOAD) && bus.cfg_we) begin
            table_r[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // One-deep result register; a simultaneous consume and accept refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r         <= INIT;
            out_valid_r   <= 1'b0;
            out_changed_r <= 1'b0;
        end else if (accept_s) begin
            out_r         <= next_s;
            out_changed_r <= (next_s != out_r);
            out_valid_r   <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_udp_seq_eval.sv
// tb_udp_seq_eval: directed vectors with hand-computed results for
// udp_seq_eval (NIN=2, INIT=1). Stimulus pushes expected {out, out_changed}
// into a queue; a monitor pops and compares whenever a result is consumed.
`timescale 1ns/1ps
module tb_udp_seq_eval;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_q [$];

    udp_seq_eval_if #(.NIN(2)) bus ();

    udp_seq_eval #(.NIN(2), .INIT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a result is consumed at the next edge when valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {6'd0, bus.out, bus.out_changed}, 8'hff);
                end else begin
                    chk("result", {6'd0, bus.out, bus.out_changed}, {6'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_out", {7'd0, bus.out}, 8'd1);
        chk("rst_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_locked", {7'd0, bus.locked}, 8'd0);
        chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd0);
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [1:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_lock();
        bus.cfg_lock = 1'b1;
        @(posedge clk); #1;
        bus.cfg_lock = 1'b0;
        @(negedge clk);
        chk("locked", {7'd0, bus.locked}, 8'd1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] d, input logic eo, input logic ec);
        bit done = 1'b0;
        bus.in_data = d; bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back({eo, ec});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_data = 2'b00; bus.cfg_lock = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 2'b00; bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Unprogrammed table holds INIT; in_valid ignored in LOAD.
        do_reset();
        bus.in_valid = 1'b1; bus.in_data = 2'b01;
        repeat (2) begin
            @(negedge clk);
            chk("load_in_ready", {7'd0, bus.in_ready}, 8'd0);
            chk("load_no_valid", {7'd0, bus.out_valid}, 8'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        do_lock();
        send(2'b00, 1'b1, 1'b0);
        send(2'b01, 1'b1, 1'b0);
        drain();

        // Inverter on in[0] (in[1]=0).
        do_reset();
        cfg_write(3'b000, 2'b01); cfg_write(3'b001, 2'b00);
        cfg_write(3'b100, 2'b01); cfg_write(3'b101, 2'b00);
        do_lock();
        send(2'b00, 1'b1, 1'b0);
        send(2'b01, 1'b0, 1'b1);
        send(2'b01, 1'b0, 1'b0);
        send(2'b00, 1'b1, 1'b1);
        drain();

        // Latch: in[1]=enable, in[0]=d.
        do_reset();
        cfg_write(3'b010, 2'b00); cfg_write(3'b011, 2'b01);
        cfg_write(3'b110, 2'b00); cfg_write(3'b111, 2'b01);
        do_lock();
        send(2'b10, 1'b0, 1'b1);
        send(2'b01, 1'b0, 1'b0);
        send(2'b11, 1'b1, 1'b1);
        send(2'b00, 1'b1, 1'b0);
        drain();

        // Backpressure: one pending result, next vector stalls for 3 cycles.
        bus.out_ready = 1'b0;
        send(2'b10, 1'b0, 1'b1);
        bus.in_data = 2'b11; bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {7'd0, bus.in_ready}, 8'd0);
            chk("bp_valid", {7'd0, bus.out_valid}, 8'd1);
            chk("bp_out", {7'd0, bus.out}, 8'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {7'd0, bus.in_ready}, 8'd1);
        exp_q.push_back(2'b11);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_no_bubble", {7'd0, bus.out_valid}, 8'd1);
        drain();

        // Write and lock in the same cycle; later writes in RUN are ignored.
        do_reset();
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'b101; bus.cfg_data = 2'b00; bus.cfg_lock = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0; bus.cfg_lock = 1'b0;
        @(negedge clk);
        chk("we_lock_locked", {7'd0, bus.locked}, 8'd1);
        @(posedge clk); #1;
        send(2'b01, 1'b0, 1'b1);
        cfg_write(3'b001, 2'b01);
        send(2'b01, 1'b0, 1'b0);
        drain();

        // Reset with a pending result discards it and clears the table.
        bus.out_ready = 1'b0;
        send(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("pend_valid", {7'd0, bus.out_valid}, 8'd1);
        @(posedge clk); #1;
        do_reset();
        bus.out_ready = 1'b1;
        do_lock();
        send(2'b01, 1'b1, 1'b0);
        send(2'b00, 1'b1, 1'b0);
        drain();

        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
